// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector: gathers OVL checker fire vectors into saturating
// per-checker failure counters and sticky X-check/cover flags, records the
// first assertion failure (index and timestamp) with a one-cycle interrupt,
// and clears all collected state through a clear_req/clear_ack handshake.
module ovl_fire_collector #(
   parameter int num_checkers = 4,
   parameter int idx_width    = 2,
   parameter int count_width  = 8,
   parameter int ts_width     = 16
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                enable,
   input  logic [3*num_checkers-1:0]           fire_in,
   input  logic                                clear_req,
   output logic                                clear_ack,
   output logic [count_width*num_checkers-1:0] fail_count,
   output logic [num_checkers-1:0]             xcheck_seen,
   output logic [num_checkers-1:0]             cover_seen,
   output logic                                any_fail,
   output logic                                first_valid,
   output logic [idx_width-1:0]                first_idx,
   output logic [ts_width-1:0]                 first_time,
   output logic                                irq
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURED,
      CLEAR,
      WAIT_REQ_LOW
   } state_t;

   state_t                 state_q;
   logic [ts_width-1:0]    ts_q;
   logic [count_width-1:0] count_q [num_checkers];
   logic [num_checkers-1:0] xcheck_q;
   logic [num_checkers-1:0] cover_q;
   logic                   any_fail_q;
   logic                   first_valid_q;
   logic [idx_width-1:0]   first_idx_q;
   logic [ts_width-1:0]    first_time_q;
   logic                   irq_q;
   logic                   clear_ack_q;

   logic [num_checkers-1:0] fail_vec;
   logic [num_checkers-1:0] xcheck_vec;
   logic [num_checkers-1:0] cover_vec;
   logic [idx_width-1:0]    lowest_idx;
   logic                    any_bit0;
   logic                    clear_accept;
   logic                    sample_en;
   logic                    capture;

   // Split the fire vector per event type and find the lowest failing checker.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      fail_vec   = '0;
      xcheck_vec = '0;
      cover_vec  = '0;
      lowest_idx = '0;
      // Walking downwards lets the lowest set index be the last one written.
      for (int i = num_checkers - 1; i >= 0; i--) begin
         fail_vec[i]   = fire_in[3*i];
         xcheck_vec[i] = fire_in[3*i+1];
         cover_vec[i]  = fire_in[3*i+2];
         if (fire_in[3*i]) begin
            lowest_idx = idx_width'(i);
         end
      end
   end

   // A clear is only accepted from IDLE/CAPTURED, and it beats a same-cycle capture.
   assign any_bit0     = |fail_vec;
   assign clear_accept = clear_req && ((state_q == IDLE) || (state_q == CAPTURED));
   assign sample_en    = enable && (state_q != CLEAR) && !clear_accept;
   assign capture      = sample_en && any_bit0 && !first_valid_q;

   // Collector state, timestamp, handshake FSM and registered outputs.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q       <= IDLE;
         ts_q          <= '0;
         // NOTE: the counter array is reset explicitly because its contents are visible outputs.
         for (int i = 0; i < num_checkers; i++) begin
            count_q[i] <= '0;
         end
         xcheck_q      <= '0;
         cover_q       <= '0;
         any_fail_q    <= 1'b0;
         first_valid_q <= 1'b0;
         first_idx_q   <= '0;
         first_time_q  <= '0;
         irq_q         <= 1'b0;
         clear_ack_q   <= 1'b0;
      end else begin
         irq_q       <= 1'b0;
         clear_ack_q <= 1'b0;
         // The timestamp keeps running through a clear; only reset zeroes it.
         if (enable) begin
            ts_q <= ts_q + ts_width'(1);
         end

         if (clear_accept) begin
            for (int i = 0; i < num_checkers; i++) begin
               count_q[i] <= '0;
            end
            xcheck_q      <= '0;
            cover_q       <= '0;
            any_fail_q    <= 1'b0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            first_time_q  <= '0;
            clear_ack_q   <= 1'b1;
            state_q       <= CLEAR;
         end else begin
            if (sample_en) begin
               for (int i = 0; i < num_checkers; i++) begin
                  if (fail_vec[i] && (count_q[i] != {count_width{1'b1}})) begin
                     count_q[i] <= count_q[i] + count_width'(1);
                  end
               end
               xcheck_q <= xcheck_q | xcheck_vec;
               cover_q  <= cover_q | cover_vec;
               if (any_bit0) begin
                  any_fail_q <= 1'b1;
               end
            end

            if (capture) begin
               first_valid_q <= 1'b1;
               first_idx_q   <= lowest_idx;
               first_time_q  <= ts_q;
               irq_q         <= 1'b1;
            end

            case (state_q)
               IDLE: begin
                  if (capture) begin
                     state_q <= CAPTURED;
                  end
               end
               CAPTURED: begin
                  state_q <= CAPTURED;
               end
               CLEAR: begin
                  state_q <= WAIT_REQ_LOW;
               end
               WAIT_REQ_LOW: begin
                  // Stay here until the request drops so a held request clears once.
                  if (!clear_req) begin
                     state_q <= (first_valid_q || capture) ? CAPTURED : IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   // Pack the per-checker counters onto the flat output bus.
   always_comb begin
      fail_count = '0;
      for (int i = 0; i < num_checkers; i++) begin
         fail_count[i*count_width +: count_width] = count_q[i];
      end
   end

   assign xcheck_seen = xcheck_q;
   assign cover_seen  = cover_q;
   assign any_fail    = any_fail_q;
   assign first_valid = first_valid_q;
   assign first_idx   = first_idx_q;
   assign first_time  = first_time_q;
   assign irq         = irq_q;
   assign clear_ack   = clear_ack_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Testbench for ovl_fire_collector: table-driven vectors plus hand-written
// saturation and timestamp-wrap sequences, compared through a scoreboard queue.
module tb_ovl_fire_collector;

   localparam int NC = 4;
   localparam int IW = 2;
   localparam int CW = 8;
   localparam int TW = 16;

   logic              clock;
   logic              reset;
   logic              enable;
   logic [3*NC-1:0]   fire_in;
   logic              clear_req;
   logic              clear_ack;
   logic [CW*NC-1:0]  fail_count;
   logic [NC-1:0]     xcheck_seen;
   logic [NC-1:0]     cover_seen;
   logic              any_fail;
   logic              first_valid;
   logic [IW-1:0]     first_idx;
   logic [TW-1:0]     first_time;
   logic              irq;

   typedef struct packed {
      logic          ack;
      logic [31:0]   fc;
      logic [3:0]    xs;
      logic [3:0]    cs;
      logic          af;
      logic          fv;
      logic [1:0]    fi;
      logic [15:0]   ft;
      logic          irq;
   } out_t;

   typedef struct {
      string         name;
      logic          rst;
      logic          en;
      logic          clr;
      logic [11:0]   fire;
      out_t          exp;
   } vec_t;

   vec_t   tbl[$];
   out_t   exp_q[$];
   string  name_q[$];
   out_t   act;
   int     n_checks = 0;
   int     n_fail   = 0;

   ovl_fire_collector #(
      .num_checkers (NC),
      .idx_width    (IW),
      .count_width  (CW),
      .ts_width     (TW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .fire_in      (fire_in),
      .clear_req    (clear_req),
      .clear_ack    (clear_ack),
      .fail_count   (fail_count),
      .xcheck_seen  (xcheck_seen),
      .cover_seen   (cover_seen),
      .any_fail     (any_fail),
      .first_valid  (first_valid),
      .first_idx    (first_idx),
      .first_time   (first_time),
      .irq          (irq)
   );

   assign act = {clear_ack, fail_count, xcheck_seen, cover_seen, any_fail,
                 first_valid, first_idx, first_time, irq};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic out_t mk(input logic ack, input logic [31:0] fc, input logic [3:0] xs,
                               input logic [3:0] cs, input logic af, input logic fv,
                               input logic [1:0] fi, input logic [15:0] ft, input logic irq_v);
      out_t o;
      o.ack = ack; o.fc = fc; o.xs = xs; o.cs = cs; o.af = af;
      o.fv = fv; o.fi = fi; o.ft = ft; o.irq = irq_v;
      return o;
   endfunction

   function automatic void add(input string name, input logic r, input logic e, input logic c,
                               input logic [11:0] f, input out_t exp);
      vec_t v;
      v.name = name; v.rst = r; v.en = e; v.clr = c; v.fire = f; v.exp = exp;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual ack=%0b fc=%h xs=%h cs=%h af=%0b fv=%0b fi=%0d ft=%0d irq=%0b | required ack=%0b fc=%h xs=%h cs=%h af=%0b fv=%0b fi=%0d ft=%0d irq=%0b",
                  name, act.ack, act.fc, act.xs, act.cs, act.af, act.fv, act.fi, act.ft, act.irq,
                  exp.ack, exp.fc, exp.xs, exp.cs, exp.af, exp.fv, exp.fi, exp.ft, exp.irq);
      end
   endtask

   // Drive one cycle at the falling edge, record the expectation, compare after the rising edge.
   task automatic step(input string name, input logic r, input logic e, input logic c,
                       input logic [11:0] f, input out_t exp);
      @(negedge clock);
      reset     = r;
      enable    = e;
      clear_req = c;
      fire_in   = f;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clock);
      #1;
      check(name_q.pop_front(), exp_q.pop_front());
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      out_t z;
      out_t held;
      z = mk(0, 32'h0, 4'h0, 4'h0, 0, 0, 2'd0, 16'd0, 0);

      reset     = 1'b1;
      enable    = 1'b0;
      clear_req = 1'b0;
      fire_in   = '0;

      // Single failure on checker 2 at ts=5.
      add("rst_state",  1, 0, 0, 12'h000, z);
      add("rst_fire",   1, 1, 0, 12'hFFF, z);
      for (int i = 0; i < 5; i++) add("idle_ts", 0, 1, 0, 12'h000, z);
      add("single_fail", 0, 1, 0, 12'h040, mk(0, 32'h0001_0000, 4'h0, 4'h0, 1, 1, 2'd2, 16'd5, 1));
      add("single_hold", 0, 1, 0, 12'h000, mk(0, 32'h0001_0000, 4'h0, 4'h0, 1, 1, 2'd2, 16'd5, 0));

      // Simultaneous failures on checkers 3 and 1, then checker 0.
      add("rst_b",      1, 1, 0, 12'h000, z);
      add("simul_fail", 0, 1, 0, 12'h208, mk(0, 32'h0100_0100, 4'h0, 4'h0, 1, 1, 2'd1, 16'd0, 1));
      add("later_fail", 0, 1, 0, 12'h001, mk(0, 32'h0100_0101, 4'h0, 4'h0, 1, 1, 2'd1, 16'd0, 0));

      // Enable gating, timestamp freeze and sticky flags.
      add("rst_e",       1, 1, 0, 12'h000, z);
      add("dis_fire0",   0, 0, 0, 12'hFFF, z);
      add("dis_fire1",   0, 0, 0, 12'hFFF, z);
      add("sticky",      0, 1, 0, 12'hC00, mk(0, 32'h0, 4'h8, 4'h8, 0, 0, 2'd0, 16'd0, 0));
      add("sticky_hold", 0, 1, 0, 12'h000, mk(0, 32'h0, 4'h8, 4'h8, 0, 0, 2'd0, 16'd0, 0));
      add("dis_fail",    0, 0, 0, 12'h001, mk(0, 32'h0, 4'h8, 4'h8, 0, 0, 2'd0, 16'd0, 0));
      add("ts_frozen",   0, 1, 0, 12'h001, mk(0, 32'h1, 4'h8, 4'h8, 1, 1, 2'd0, 16'd2, 1));

      // Clear handshake with clear_req held for 10 cycles.
      held = mk(0, 32'h0001_0000, 4'h0, 4'h0, 1, 1, 2'd2, 16'd3, 0);
      add("rst_c",         1, 1, 0, 12'h000, z);
      add("pre_fail",      0, 1, 0, 12'h008, mk(0, 32'h100, 4'h0, 4'h0, 1, 1, 2'd1, 16'd0, 1));
      add("clr_accept",    0, 1, 1, 12'h000, mk(1, 32'h0, 4'h0, 4'h0, 0, 0, 2'd0, 16'd0, 0));
      add("ack_fire_lost", 0, 1, 1, 12'h001, z);
      add("post_ack_fail", 0, 1, 1, 12'h040, mk(0, 32'h0001_0000, 4'h0, 4'h0, 1, 1, 2'd2, 16'd3, 1));
      for (int i = 0; i < 7; i++) add("req_held", 0, 1, 1, 12'h000, held);
      add("req_low",       0, 1, 0, 12'h000, held);
      add("clr_again",     0, 1, 1, 12'h000, mk(1, 32'h0, 4'h0, 4'h0, 0, 0, 2'd0, 16'd0, 0));
      add("clr_again_end", 0, 1, 0, 12'h000, z);
      add("wait_to_idle",  0, 1, 0, 12'h000, z);

      // Reset during CLEAR and during CAPTURED.
      add("clr_r",        0, 1, 1, 12'h000, mk(1, 32'h0, 4'h0, 4'h0, 0, 0, 2'd0, 16'd0, 0));
      add("rst_in_clear", 1, 1, 1, 12'h000, z);
      add("after_rst1",   0, 1, 0, 12'h200, mk(0, 32'h0100_0000, 4'h0, 4'h0, 1, 1, 2'd3, 16'd0, 1));
      add("rst_in_capt",  1, 1, 0, 12'h000, z);
      add("after_rst2",   0, 1, 0, 12'h001, mk(0, 32'h1, 4'h0, 4'h0, 1, 1, 2'd0, 16'd0, 1));

      foreach (tbl[k]) begin
         step(tbl[k].name, tbl[k].rst, tbl[k].en, tbl[k].clr, tbl[k].fire, tbl[k].exp);
      end

      // Saturation: checker 0 bit0 held for 300 cycles.
      step("rst_sat", 1, 1, 0, 12'h000, z);
      for (int n = 1; n <= 300; n++) begin
         logic [7:0] c;
         c = (n > 255) ? 8'd255 : 8'(n);
         step("saturate", 0, 1, 0, 12'h001,
              mk(0, {24'h0, c}, 4'h0, 4'h0, 1, 1, 2'd0, 16'd0, (n == 1)));
      end

      // Timestamp wrap: 65536 idle cycles bring ts back to 0.
      step("rst_wrap", 1, 1, 0, 12'h000, z);
      for (int i = 0; i < 65536; i++) begin
         @(negedge clock);
         reset     = 1'b0;
         enable    = 1'b1;
         clear_req = 1'b0;
         fire_in   = '0;
      end
      step("wrap_fail", 0, 1, 0, 12'h008, mk(0, 32'h100, 4'h0, 4'h0, 1, 1, 2'd1, 16'd0, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
